// File: rtl/xor_arb_pkg.sv
// Shared types and constants for the XOR-unit sharing arbiter.
package xor_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam int TIMEOUT_CYC_DEF = 16;

  // Requester index width; never narrower than one bit.
  function automatic int id_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/xor_share_arbiter_rr_pick.sv
// Round-robin picker: first requester at or after ptr, searching upward with wrap.
module rr_pick
  import xor_arb_pkg::*;
#(
  parameter int  N_REQ = 4,
  localparam int IW    = id_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IW-1:0]    idx,
  output logic             any
);

  // Upper segment [ptr..N-1] first, then the wrapped segment from 0.
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!any && req[i] && (i >= int'(ptr))) begin
        any = 1'b1;
        idx = IW'(i);
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!any && req[i]) begin
        any = 1'b1;
        idx = IW'(i);
      end
    end
    gnt = any ? (N_REQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/xor_share_arbiter.sv
// Shares one delayed XOR unit among N_REQ requesters, one transaction at a time.
// Optional WAIT-state timeout enabled by defining XSA_TIMEOUT_EN.
module xor_share_arbiter
  import xor_arb_pkg::*;
#(
  parameter int  N_REQ       = 4,
  parameter int  TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  localparam int IW          = id_w(N_REQ)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [N_REQ-1:0] req_valid,
  input  logic [N_REQ-1:0] req_a,
  input  logic [N_REQ-1:0] req_b,
  output logic [N_REQ-1:0] req_rdy,
  output logic             rsp_valid,
  output logic             rsp_data,
  output logic [IW-1:0]    rsp_id,
  output logic             rsp_err,
  input  logic             rsp_rdy,
  output logic             dut_a_data,
  output logic             dut_a_en,
  input  logic             dut_a_rdy,
  output logic             dut_b_data,
  output logic             dut_b_en,
  input  logic             dut_b_rdy,
  input  logic             dut_y_data,
  input  logic             dut_y_en,
  output logic             dut_y_rdy
);

  state_t           state;
  logic [IW-1:0]    ptr, id;
  logic             op_a, op_b;
  logic             a_done, b_done;
  logic [N_REQ-1:0] gnt;
  logic [IW-1:0]    gidx;
  logic             any;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req (req_valid),
    .ptr (ptr),
    .gnt (gnt),
    .idx (gidx),
    .any (any)
  );

  assign req_rdy    = (state == IDLE) ? gnt : '0;
  assign rsp_valid  = (state == RESP);
  assign rsp_id     = id;
  // The unit samples data a cycle after accepting it, so operands stay
  // on the bus until the next grant replaces them.
  assign dut_a_data = op_a;
  assign dut_b_data = op_b;
  assign dut_a_en   = (state == ISSUE) && !a_done;
  assign dut_b_en   = (state == ISSUE) && !b_done;
  assign dut_y_rdy  = (state == WAIT);

`ifdef XSA_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt;
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYC != 0);
  assign rsp_err    = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state    <= IDLE;
      ptr      <= '0;
      id       <= '0;
      op_a     <= 1'b0;
      op_b     <= 1'b0;
      a_done   <= 1'b0;
      b_done   <= 1'b0;
      rsp_data <= 1'b0;
`ifdef XSA_TIMEOUT_EN
      rsp_err  <= 1'b0;
      cnt      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any) begin
            id    <= gidx;
            op_a  <= req_a[gidx];
            op_b  <= req_b[gidx];
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (dut_a_en && dut_a_rdy) a_done <= 1'b1;
          if (dut_b_en && dut_b_rdy) b_done <= 1'b1;
          if ((a_done || dut_a_rdy) && (b_done || dut_b_rdy)) state <= WAIT;
`ifdef XSA_TIMEOUT_EN
          cnt <= '0;
`endif
        end
        WAIT: begin
          if (dut_y_en) begin
            rsp_data <= dut_y_data;
`ifdef XSA_TIMEOUT_EN
            rsp_err  <= 1'b0;
`endif
            state    <= RESP;
          end
`ifdef XSA_TIMEOUT_EN
          else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
            rsp_data <= 1'b0;
            rsp_err  <= 1'b1;
            state    <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          if (rsp_rdy) begin
            state  <= IDLE;
            a_done <= 1'b0;
            b_done <= 1'b0;
            ptr    <= (id == IW'(N_REQ - 1)) ? '0 : id + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xor_share_arbiter.sv
// Directed bench for xor_share_arbiter with a behavioural delayed XOR unit.
module tb_xor_share_arbiter;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [3:0] req_valid, req_a, req_b, req_rdy;
  logic       rsp_valid, rsp_data, rsp_err, rsp_rdy;
  logic [1:0] rsp_id;
  logic       dut_a_data, dut_a_en, dut_a_rdy;
  logic       dut_b_data, dut_b_en, dut_b_rdy;
  logic       dut_y_data, dut_y_en, dut_y_rdy;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  xor_share_arbiter #(.N_REQ(4), .TIMEOUT_CYC(16)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_rdy(req_rdy),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .rsp_err(rsp_err), .rsp_rdy(rsp_rdy),
    .dut_a_data(dut_a_data), .dut_a_en(dut_a_en), .dut_a_rdy(dut_a_rdy),
    .dut_b_data(dut_b_data), .dut_b_en(dut_b_en), .dut_b_rdy(dut_b_rdy),
    .dut_y_data(dut_y_data), .dut_y_en(dut_y_en), .dut_y_rdy(dut_y_rdy)
  );

  // Delayed XOR unit: samples operands one cycle after both are accepted.
  logic ga, gb, yv, yd, y_block;
  assign dut_y_en   = yv;
  assign dut_y_data = yd;

  always @(posedge CLK) begin
    if (!RST_N) begin
      ga <= 1'b0; gb <= 1'b0; yv <= 1'b0; yd <= 1'b0;
    end else begin
      if (dut_a_en && dut_a_rdy) ga <= 1'b1;
      if (dut_b_en && dut_b_rdy) gb <= 1'b1;
      if (ga && gb && !yv && !y_block) begin
        yd <= dut_a_data ^ dut_b_data;
        yv <= 1'b1;
        ga <= 1'b0;
        gb <= 1'b0;
      end
      if (yv && dut_y_rdy) yv <= 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_req_rdy"}, 32'(req_rdy), 0);
    chk({nm, "_rsp"}, {rsp_valid, rsp_data, rsp_id, rsp_err}, 0);
    chk({nm, "_dut"}, {dut_a_en, dut_a_data, dut_b_en, dut_b_data, dut_y_rdy}, 0);
  endtask

  typedef struct {
    logic [3:0] vld, a, b, gnt;
    logic [1:0] id;
    logic       d;
  } vec_t;

  // Starts and ends at a drive point in IDLE; expects T+4 response latency.
  task automatic run_txn(input vec_t v, input string nm);
    req_valid = v.vld; req_a = v.a; req_b = v.b;
    #1 chk({nm, "_gnt"}, 32'(req_rdy), 32'(v.gnt));
    tick(); req_valid = '0;
    tick();
    tick(); #1 chk({nm, "_early"}, 32'(rsp_valid), 0);
    tick();
    #1 chk({nm, "_valid"}, 32'(rsp_valid), 1);
    chk({nm, "_data"}, 32'(rsp_data), 32'(v.d));
    chk({nm, "_id"}, 32'(rsp_id), 32'(v.id));
    chk({nm, "_err"}, 32'(rsp_err), 0);
    tick();
  endtask

  vec_t       tbl[7];
  logic [3:0] rr_x;

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{4'b0001, 4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b1};
    tbl[1] = '{4'b0001, 4'b0000, 4'b0001, 4'b0001, 2'd0, 1'b1};
    tbl[2] = '{4'b1100, 4'b1000, 4'b1100, 4'b0100, 2'd2, 1'b1};
    tbl[3] = '{4'b1111, 4'b1010, 4'b0110, 4'b1000, 2'd3, 1'b1};
    tbl[4] = '{4'b0110, 4'b0010, 4'b0010, 4'b0010, 2'd1, 1'b0};
    tbl[5] = '{4'b0011, 4'b0001, 4'b0010, 4'b0001, 2'd0, 1'b1};
    tbl[6] = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 2'd3, 1'b0};

    RST_N = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
    rsp_rdy = 1'b1; dut_a_rdy = 1'b1; dut_b_rdy = 1'b1; y_block = 1'b0;
    tick(); tick();
    #1 chk_zero("reset");
    RST_N = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

    // All requesters valid: grants 0,1,2,3,0 spaced five cycles apart.
    req_valid = 4'b1111; req_a = 4'b0101; req_b = 4'b0011;
    rr_x = req_a ^ req_b;
    for (int k = 0; k < 5; k++) begin
      #1 chk("rr_gnt", 32'(req_rdy), 32'(4'b0001) << (k % 4));
      tick(); tick(); tick();
      #1 chk("rr_early", 32'(rsp_valid), 0);
      tick();
      #1 chk("rr_valid", 32'(rsp_valid), 1);
      chk("rr_id", 32'(rsp_id), 32'(k % 4));
      chk("rr_data", 32'(rsp_data), 32'(rr_x[k % 4]));
      chk("rr_no_gnt", 32'(req_rdy), 0);
      tick();
    end
    req_valid = '0;

    // Port b stalls three ISSUE cycles; ptr is 1 here.
    req_valid = 4'b0010; req_a = 4'b0010; req_b = 4'b0000; dut_b_rdy = 1'b0;
    #1 chk("bst_gnt", 32'(req_rdy), 32'(4'b0010));
    tick(); req_valid = '0;
    #1 chk("bst_en1", {dut_a_en, dut_b_en, dut_a_data, dut_b_data}, 4'b1110);
    tick();
    #1 chk("bst_en2", {dut_a_en, dut_b_en, dut_a_data, dut_b_data}, 4'b0110);
    tick();
    #1 chk("bst_en3", {dut_a_en, dut_b_en, dut_a_data, dut_b_data}, 4'b0110);
    tick(); dut_b_rdy = 1'b1;
    #1 chk("bst_en4", {dut_a_en, dut_b_en, dut_a_data, dut_b_data}, 4'b0110);
    tick();
    #1 chk("bst_wait1", {dut_y_rdy, dut_a_en, dut_b_en, dut_a_data, dut_b_data}, 5'b10010);
    tick();
    #1 chk("bst_wait2", {rsp_valid, dut_a_data, dut_b_data}, 3'b010);
    tick();
    #1 chk("bst_rsp", {rsp_valid, rsp_data, rsp_id}, 4'b1101);
    tick();

    // Consumer stalls six cycles with every requester still valid; ptr is 2.
    req_valid = 4'b1111; req_a = 4'b1100; req_b = 4'b1000; rsp_rdy = 1'b0;
    #1 chk("rst_gnt", 32'(req_rdy), 32'(4'b0100));
    tick(); tick(); tick(); tick();
    for (int k = 0; k < 6; k++) begin
      #1 chk("rstall_hold", {rsp_valid, rsp_data, rsp_id}, 4'b1110);
      chk("rstall_no_gnt", 32'(req_rdy), 0);
      tick();
    end
    rsp_rdy = 1'b1;
    #1 chk("rstall_hs", {rsp_valid, req_rdy}, 5'b10000);
    tick();
    #1 chk("rstall_next_gnt", {rsp_valid, req_rdy}, 5'b01000);
    tick(); req_valid = '0;
    tick();
    #1 chk("rst_wait", {dut_y_rdy, dut_a_data, dut_b_data}, 3'b111);

    // One-cycle reset in WAIT aborts the transaction.
    RST_N = 1'b0;
    tick(); RST_N = 1'b1;
    #1 chk_zero("midrst");
    run_txn('{4'b1111, 4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b1}, "postrst");

`ifdef XSA_TIMEOUT_EN
    y_block = 1'b1;
    req_valid = 4'b0001; req_a = 4'b0001; req_b = 4'b0000;
    #1 chk("tmo_gnt", 32'(req_rdy), 32'(4'b0001));
    tick(); req_valid = '0;
    for (int k = 0; k < 16; k++) begin
      tick();
      #1 chk("tmo_wait", {rsp_valid, dut_y_rdy}, 2'b01);
    end
    tick();
    #1 chk("tmo_rsp", {rsp_valid, rsp_err, rsp_data}, 3'b110);
    RST_N = 1'b0;
    tick(); RST_N = 1'b1; y_block = 1'b0;
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/xor_share_arbiter.md
# xor_share_arbiter

Shares one delayed XOR unit (`delayed_dut`-style a/b/y ready-enable ports) among N_REQ requesters, one transaction at a time.
- Selects a requester by round-robin and latches its operand pair.
- Drives the unit's a/b inputs and holds the operands stable until the result returns, because the unit samples data one cycle after accepting it.
- Returns the result tagged with the requester index.

Sits between requester logic and the XOR unit.

## Interface
- N_REQ, 4, number of requesters (2..16)
- TIMEOUT_CYC, 16, WAIT-state cycle limit; used only when XSA_TIMEOUT_EN is defined
- CLK  in  1  clock; all logic on rising edge
- RST_N  in  1  reset, synchronous, active-low; one clock; reset is synchronous and active-low
- req_valid  in  N_REQ  requester i presents an operand pair
- req_a, req_b  in  N_REQ  operand bits per requester
- req_rdy  out  N_REQ  one-hot grant; transfer when req_valid[i] & req_rdy[i]
- rsp_valid  out  1  result available
- rsp_data  out  1  XOR result
- rsp_id  out  $clog2(N_REQ)  index of the requester that owns the result
- rsp_err  out  1  result invalid (timeout); constant 0 without XSA_TIMEOUT_EN
- rsp_rdy  in  1  consumer accepts the result
- dut_a_data, dut_a_en  out  1  to unit port a
- dut_a_rdy  in  1
- dut_b_data, dut_b_en  out  1  to unit port b
- dut_b_rdy  in  1
- dut_y_data, dut_y_en  in  1  from unit output
- dut_y_rdy  out  1  to unit

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - If any req_valid, grant the first requester at or after ptr, searching upward with wrap.
  - Assert req_rdy[winner] combinationally in this cycle only.
  - Latch op_a, op_b and id; go to ISSUE.
  - With no requests, stay in IDLE with req_rdy=0.
- **ISSUE**
  - Assert dut_a_en while a_done=0 and dut_b_en while b_done=0.
  - Set a_done on dut_a_en & dut_a_rdy, and b_done likewise.
  - Go to WAIT once both are done; this includes both accepting in the same cycle.
- **WAIT**
  - dut_y_rdy = 1.
  - On dut_y_en: capture dut_y_data into rsp_data, set rsp_err=0 and go to RESP.
- **RESP**
  - rsp_valid = 1, with rsp_data and rsp_id held stable.
  - On rsp_rdy: go to IDLE, clear a_done/b_done, and set ptr = (id+1) mod N_REQ.
- dut_a_data/dut_b_data equal op_a/op_b continuously from ISSUE through WAIT.
  - They hold the last value in RESP/IDLE.
- dut_y_en outside WAIT is ignored, and dut_y_rdy=0 in every state except WAIT.
- A requester that drops req_valid without being granted loses nothing; no state is kept per requester.

## Timing
- Reset values: state=IDLE, ptr=0, a_done=b_done=0.
  - All outputs are 0: req_rdy, rsp_valid, rsp_data, rsp_id, rsp_err and all dut_* outputs.
- Reset mid-transaction aborts the transaction and returns to IDLE next edge. Any pending response is discarded.
  - The XOR unit must be reset on the same RST_N edge.
- Latency with an always-ready unit and rsp_rdy=1:
  - grant in cycle T
  - ISSUE in T+1
  - WAIT in T+2..T+3, with dut_y_en seen in T+3
  - rsp_valid in T+4
  - next grant no earlier than T+5
- Throughput: at most 1 transaction per 5 cycles; every additional ready stall adds 1 cycle.
- Round-robin fairness: with all requesters valid, grants cycle 0,1,…,N_REQ-1,0.
  - ptr wraps from N_REQ-1 to 0.

## Configuration
- XSA_TIMEOUT_EN defined:
  - A counter in WAIT increments each cycle.
  - If it reaches TIMEOUT_CYC without dut_y_en, go to RESP with rsp_err=1 and rsp_data=0.
  - The counter clears on entry to WAIT.
  - A late dut_y_en is then ignored; recovery requires reset.
- XSA_TIMEOUT_EN undefined: no counter; WAIT lasts indefinitely; rsp_err is tied to 0.

## Structure
- Package xor_arb_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, RESP)
  - the function that computes ID width from N_REQ
  - the default TIMEOUT_CYC
- Sub-module rr_pick, purely combinational:
  - inputs: req vector and ptr
  - outputs: one-hot grant, grant index and any-request flag
- Top level holds the FSM, operand/id registers, done flags, ptr and the optional timeout counter.

## Test plan
- Reset, then single request: req_valid=0001, a=1, b=0, unit always ready.
  - req_rdy=0001 in the same cycle.
  - rsp_valid 4 cycles later with rsp_data=1 and rsp_id=0.
- All four requesters valid continuously with rsp_rdy=1:
  - grants in order 0,1,2,3,0, spaced 5 cycles apart
  - each rsp_id matches its grant
  - every rsp_data equals a^b for that requester
- Unit dut_b_rdy held low 3 cycles in ISSUE:
  - dut_b_en stays high and dut_a_en is a single pulse.
  - Operands stay stable until the result arrives, and the result is correct.
- rsp_rdy held low 6 cycles:
  - rsp_valid/data/id stay stable.
  - No new req_rdy is issued until the cycle after the rsp handshake.
- RST_N low for 1 cycle during WAIT: next cycle all outputs are 0 and state is IDLE; ptr=0 on the next grant.
- XSA_TIMEOUT_EN with TIMEOUT_CYC=16 and dut_y_en never asserted: rsp_valid=1 with rsp_err=1 after 16 WAIT cycles.
